// File: rtl/controller_mc_pkg.sv
// Shared definitions for the multi-cycle controller and the ALU.
// Holds the ALU operation encoding, the instruction opcode/funct values
// recognised by the decoder, the controller state encoding and the
// instruction class reported by the decoder to the FSM.
package controller_mc_pkg;

    typedef enum logic [3:0] {
        ALU_NOP = 4'h0,
        ALU_ADD = 4'h1,
        ALU_SUB = 4'h2,
        ALU_AND = 4'h3,
        ALU_OR  = 4'h4,
        ALU_XOR = 4'h5,
        ALU_NOR = 4'h6,
        ALU_SLT = 4'h7,
        ALU_SLL = 4'h8,
        ALU_SRL = 4'h9,
        ALU_BEQ = 4'hA,
        ALU_BNE = 4'hB
    } alu_op_e;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, instruction bits [5:0]
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_e;

    typedef enum logic [2:0] {
        CL_RTYPE,
        CL_ITYPE,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_ILLEGAL
    } iclass_e;

endpackage

// File: rtl/controller_mc_alu_decoder.sv
// alu_decoder: combinational instruction decoder.
// Ports:
//   opcode  [5:0] in  - latched instruction bits [31:26]
//   funct   [5:0] in  - latched instruction bits [5:0]
//   alu_op  [3:0] out - ALU operation (NOP for jump/illegal)
//   illegal       out - instruction is not decodable
//   iclass        out - instruction class used by the controller FSM
module alu_decoder
    import controller_mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       illegal,
    output iclass_e    iclass
);

    always_comb begin
        alu_op = ALU_NOP;
        iclass = CL_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                iclass = CL_RTYPE;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    default: iclass = CL_ILLEGAL;
                endcase
            end
            OP_ADDI: begin alu_op = ALU_ADD; iclass = CL_ITYPE;  end
            OP_ANDI: begin alu_op = ALU_AND; iclass = CL_ITYPE;  end
            OP_ORI:  begin alu_op = ALU_OR;  iclass = CL_ITYPE;  end
            OP_SLTI: begin alu_op = ALU_SLT; iclass = CL_ITYPE;  end
            OP_LW:   begin alu_op = ALU_ADD; iclass = CL_LOAD;   end
            OP_SW:   begin alu_op = ALU_ADD; iclass = CL_STORE;  end
            OP_BEQ:  begin alu_op = ALU_BEQ; iclass = CL_BRANCH; end
            OP_BNE:  begin alu_op = ALU_BNE; iclass = CL_BRANCH; end
            OP_J:    begin alu_op = ALU_NOP; iclass = CL_JUMP;   end
            default: begin alu_op = ALU_NOP; iclass = CL_ILLEGAL; end
        endcase
    end

    assign illegal = (iclass == CL_ILLEGAL);

endmodule

// File: rtl/controller_mc.sv
// controller_mc: multi-cycle processor control FSM
// (FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH).
// Ports:
//   clk, rst (async, active low)
//   opcode, funct   - instruction fields, latched in DECODE
//   Zero            - ALU zero/condition flag, used in EXEC for branches
//   mem_ready       - memory handshake, honoured only in FETCH and MEM
//   ALUOp           - ALU operation, NOP outside EXEC
//   MemRead/MemWrite, IRWrite/PCWrite/RegWrite - strobes and enables
//   PCSrc           - 0 PC+4, 1 branch target, 2 jump target
//   IorD, ALUSrc, RegDst, MemtoReg - datapath mux selects
//   illegal         - single-cycle flag for an undecodable instruction
module controller_mc
    import controller_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic [3:0] ALUOp,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       ALUSrc,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       illegal
);

    state_e     state, state_nxt;
    logic [5:0] op_q, fn_q;

    logic [3:0] dec_alu;
    logic       dec_illegal;
    iclass_e    dec_class;

    logic [3:0] alu_c;
    logic       mr_c, mw_c, irw_c, pcw_c, rw_c;
    logic [1:0] pcsrc_c;
    logic       iord_c, alusrc_c, regdst_c, m2r_c, ill_c;

    alu_decoder u_dec (
        .opcode  (op_q),
        .funct   (fn_q),
        .alu_op  (dec_alu),
        .illegal (dec_illegal),
        .iclass  (dec_class)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FETCH;
            op_q  <= '0;
            fn_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        alu_c     = ALU_NOP;
        mr_c      = 1'b0;
        mw_c      = 1'b0;
        irw_c     = 1'b0;
        pcw_c     = 1'b0;
        rw_c      = 1'b0;
        pcsrc_c   = 2'd0;
        iord_c    = 1'b0;
        alusrc_c  = 1'b0;
        regdst_c  = 1'b0;
        m2r_c     = 1'b0;
        ill_c     = 1'b0;
        case (state)
            ST_FETCH: begin
                mr_c = 1'b1;
                if (mem_ready) begin
                    irw_c     = 1'b1;
                    pcw_c     = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC: begin
                alu_c = dec_alu;
                ill_c = dec_illegal;
                case (dec_class)
                    CL_RTYPE: state_nxt = ST_WB;
                    CL_ITYPE: begin
                        alusrc_c  = 1'b1;
                        state_nxt = ST_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        alusrc_c  = 1'b1;
                        state_nxt = ST_MEM;
                    end
                    CL_BRANCH: begin
                        // For both beq and bne the ALU raises Zero when the
                        // branch condition holds, so Zero alone decides taken.
                        if (Zero) begin
                            pcw_c   = 1'b1;
                            pcsrc_c = 2'd1;
                        end
                        state_nxt = ST_FETCH;
                    end
                    CL_JUMP: begin
                        pcw_c     = 1'b1;
                        pcsrc_c   = 2'd2;
                        state_nxt = ST_FETCH;
                    end
                    default: state_nxt = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                iord_c = 1'b1;
                if (dec_class == CL_LOAD) mr_c = 1'b1;
                else                      mw_c = 1'b1;
                if (mem_ready)
                    state_nxt = (dec_class == CL_LOAD) ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
                rw_c      = 1'b1;
                regdst_c  = (dec_class == CL_RTYPE);
                m2r_c     = (dec_class == CL_LOAD);
                state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    // The state register already sits in FETCH during reset; masking with
    // rst keeps every output at 0/NOP until release, independent of clk.
    assign ALUOp    = rst ? alu_c : '0;
    assign MemRead  = rst & mr_c;
    assign MemWrite = rst & mw_c;
    assign IRWrite  = rst & irw_c;
    assign PCWrite  = rst & pcw_c;
    assign RegWrite = rst & rw_c;
    assign PCSrc    = rst ? pcsrc_c : '0;
    assign IorD     = rst & iord_c;
    assign ALUSrc   = rst & alusrc_c;
    assign RegDst   = rst & regdst_c;
    assign MemtoReg = rst & m2r_c;
    assign illegal  = rst & ill_c;

endmodule

// File: tb/tb_controller_mc.sv
// Self-checking bench for controller_mc: directed vector table, hand-written
// reset/memory-wait sequences, and random instruction streams checked cycle
// by cycle against a per-instruction expected output trace.
module tb_controller_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       Zero, mem_ready;
    logic [3:0] ALUOp;
    logic       MemRead, MemWrite, IRWrite, PCWrite, RegWrite;
    logic [1:0] PCSrc;
    logic       IorD, ALUSrc, RegDst, MemtoReg, illegal;

    int checks = 0;
    int errors = 0;

    controller_mc dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct     (funct),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .ALUOp     (ALUOp),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .PCSrc     (PCSrc),
        .IorD      (IorD),
        .ALUSrc    (ALUSrc),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output bundle: {ALUOp, MemRead, MemWrite, IRWrite, PCWrite, RegWrite,
    //                 PCSrc, IorD, ALUSrc, RegDst, MemtoReg, illegal}
    function automatic logic [15:0] outs();
        return {ALUOp, MemRead, MemWrite, IRWrite, PCWrite, RegWrite,
                PCSrc, IorD, ALUSrc, RegDst, MemtoReg, illegal};
    endfunction

    function automatic logic [15:0] mk(input logic [3:0] alu,
                                       input logic mr, mw, irw, pcw, rw,
                                       input logic [1:0] pcsrc,
                                       input logic iord, alusrc, regdst, m2r, ill);
        return {alu, mr, mw, irw, pcw, rw, pcsrc, iord, alusrc, regdst, m2r, ill};
    endfunction

    function automatic logic [15:0] ex(input logic [3:0] alu, input logic pcw,
                                       input logic [1:0] pcsrc,
                                       input logic alusrc, ill);
        return mk(alu, 0, 0, 0, pcw, 0, pcsrc, 0, alusrc, 0, 0, ill);
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] rb6();
        return 6'($urandom);
    endfunction

    // ---------------- reference model ----------------
    // R-type funct -> {legal, ALUOp}
    function automatic logic [4:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20: return {1'b1, 4'h1};
            6'h22: return {1'b1, 4'h2};
            6'h24: return {1'b1, 4'h3};
            6'h25: return {1'b1, 4'h4};
            6'h26: return {1'b1, 4'h5};
            6'h27: return {1'b1, 4'h6};
            6'h2A: return {1'b1, 4'h7};
            6'h00: return {1'b1, 4'h8};
            6'h02: return {1'b1, 4'h9};
            default: return 5'h0;
        endcase
    endfunction

    // I-type opcode -> {legal, ALUOp}
    function automatic logic [4:0] i_alu(input logic [5:0] op);
        case (op)
            6'h08: return {1'b1, 4'h1};
            6'h0C: return {1'b1, 4'h3};
            6'h0D: return {1'b1, 4'h4};
            6'h0A: return {1'b1, 4'h7};
            default: return 5'h0;
        endcase
    endfunction

    typedef struct {
        logic        mr;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] exp;
    } step_t;

    step_t tr[$];

    task automatic add(input logic mr, input logic [5:0] op, input logic [5:0] fn,
                       input logic [15:0] e);
        step_t s;
        s.mr = mr; s.op = op; s.fn = fn; s.exp = e;
        tr.push_back(s);
    endtask

    // Expected cycle-by-cycle trace for one instruction. Each step carries the
    // mem_ready/opcode/funct values to drive; mem_ready is random wherever the
    // controller must ignore it, and opcode/funct are junk outside DECODE.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fw, input int mw);
        logic [4:0]  r, i;
        logic [15:0] mem_v;
        logic        is_lw;
        tr.delete();
        for (int k = 0; k < fw; k++) add(1'b0, rb6(), rb6(), mk(0,1,0,0,0,0,0,0,0,0,0,0));
        add(1'b1, rb6(), rb6(), mk(0,1,0,1,1,0,0,0,0,0,0,0));
        add(1'($urandom), op, fn, 16'h0);
        r = r_alu(fn);
        i = i_alu(op);
        if (op == 6'h00 && r[4]) begin
            add(1'($urandom), rb6(), rb6(), ex(r[3:0], 0, 0, 0, 0));
            add(1'($urandom), rb6(), rb6(), mk(0,0,0,0,0,1,0,0,0,1,0,0));
        end else if (i[4]) begin
            add(1'($urandom), rb6(), rb6(), ex(i[3:0], 0, 0, 1, 0));
            add(1'($urandom), rb6(), rb6(), mk(0,0,0,0,0,1,0,0,0,0,0,0));
        end else if (op == 6'h23 || op == 6'h2B) begin
            is_lw = (op == 6'h23);
            add(1'($urandom), rb6(), rb6(), ex(4'h1, 0, 0, 1, 0));
            mem_v = mk(0, is_lw, !is_lw, 0, 0, 0, 0, 1, 0, 0, 0, 0);
            for (int k = 0; k < mw; k++) add(1'b0, rb6(), rb6(), mem_v);
            add(1'b1, rb6(), rb6(), mem_v);
            if (is_lw) add(1'($urandom), rb6(), rb6(), mk(0,0,0,0,0,1,0,0,0,0,1,0));
        end else if (op == 6'h04 || op == 6'h05) begin
            add(1'($urandom), rb6(), rb6(),
                ex((op == 6'h04) ? 4'hA : 4'hB, z, z ? 2'd1 : 2'd0, 0, 0));
        end else if (op == 6'h02) begin
            add(1'($urandom), rb6(), rb6(), ex(4'h0, 1, 2'd2, 0, 0));
        end else begin
            add(1'($urandom), rb6(), rb6(), ex(4'h0, 0, 0, 0, 1));
        end
    endtask

    // Starts just after a rising edge with the DUT in FETCH.
    task automatic apply(input string tag);
        for (int k = 0; k < tr.size(); k++) begin
            mem_ready = tr[k].mr;
            opcode    = tr[k].op;
            funct     = tr[k].fn;
            @(negedge clk);
            check($sformatf("%s c%0d", tag, k), outs(), tr[k].exp);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        @(negedge clk);
        mem_ready = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       nm;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [15:0] exec_v;
        int          cyc;
        int          rw;
        int          mw;
    } vec_t;

    vec_t vt[17];

    task automatic setv(input int i, input string nm, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input logic [15:0] e,
                        input int cyc, input int rw, input int mw);
        vt[i].nm = nm; vt[i].op = op; vt[i].fn = fn; vt[i].z = z;
        vt[i].exec_v = e; vt[i].cyc = cyc; vt[i].rw = rw; vt[i].mw = mw;
    endtask

    // Zero-wait run from a FETCH start; measures cycles until FETCH is seen
    // again, captures the EXEC outputs, and counts write strobes.
    task automatic run_vec(input int idx);
        int          cycles, rw_cnt, mw_cnt;
        logic [15:0] exv;
        cycles = 0; rw_cnt = 0; mw_cnt = 0; exv = 'x;
        opcode    = vt[idx].op;
        funct     = vt[idx].fn;
        Zero      = vt[idx].z;
        mem_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k > 0 && MemRead && !IorD) begin
                cycles = k;
                break;
            end
            if (k == 2) exv = outs();
            rw_cnt += int'(RegWrite);
            mw_cnt += int'(MemWrite);
            @(posedge clk); #1;
        end
        check({vt[idx].nm, " exec"}, exv, vt[idx].exec_v);
        check({vt[idx].nm, " cycles"}, 16'(cycles), 16'(vt[idx].cyc));
        check({vt[idx].nm, " regwrites"}, 16'(rw_cnt), 16'(vt[idx].rw));
        check({vt[idx].nm, " memwrites"}, 16'(mw_cnt), 16'(vt[idx].mw));
        if (cycles == 0) do_reset();
        else begin
            // Hold FETCH across the next edge so the following run starts clean.
            mem_ready = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    logic [5:0] op_pool[12];
    logic [5:0] fn_pool[9];

    initial begin
        op_pool = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A,
                    6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};

        setv(0,  "add",   6'h00, 6'h20, 0, ex(4'h1, 0, 0, 0, 0), 4, 1, 0);
        setv(1,  "sub",   6'h00, 6'h22, 1, ex(4'h2, 0, 0, 0, 0), 4, 1, 0);
        setv(2,  "nor",   6'h00, 6'h27, 0, ex(4'h6, 0, 0, 0, 0), 4, 1, 0);
        setv(3,  "slt",   6'h00, 6'h2A, 0, ex(4'h7, 0, 0, 0, 0), 4, 1, 0);
        setv(4,  "sll",   6'h00, 6'h00, 0, ex(4'h8, 0, 0, 0, 0), 4, 1, 0);
        setv(5,  "srl",   6'h00, 6'h02, 0, ex(4'h9, 0, 0, 0, 0), 4, 1, 0);
        setv(6,  "addi",  6'h08, 6'h15, 0, ex(4'h1, 0, 0, 1, 0), 4, 1, 0);
        setv(7,  "andi",  6'h0C, 6'h00, 0, ex(4'h3, 0, 0, 1, 0), 4, 1, 0);
        setv(8,  "slti",  6'h0A, 6'h3F, 1, ex(4'h7, 0, 0, 1, 0), 4, 1, 0);
        setv(9,  "lw",    6'h23, 6'h00, 0, ex(4'h1, 0, 0, 1, 0), 5, 1, 0);
        setv(10, "sw",    6'h2B, 6'h00, 0, ex(4'h1, 0, 0, 1, 0), 4, 0, 1);
        setv(11, "beqT",  6'h04, 6'h00, 1, ex(4'hA, 1, 1, 0, 0), 3, 0, 0);
        setv(12, "beqN",  6'h04, 6'h00, 0, ex(4'hA, 0, 0, 0, 0), 3, 0, 0);
        setv(13, "bneT",  6'h05, 6'h00, 1, ex(4'hB, 1, 1, 0, 0), 3, 0, 0);
        setv(14, "j",     6'h02, 6'h00, 0, ex(4'h0, 1, 2, 0, 0), 3, 0, 0);
        setv(15, "op3F",  6'h3F, 6'h20, 0, ex(4'h0, 0, 0, 0, 1), 3, 0, 0);
        setv(16, "fn3F",  6'h00, 6'h3F, 0, ex(4'h0, 0, 0, 0, 1), 3, 0, 0);

        // Reset: all outputs inactive, with and without clock edges.
        rst = 1'b0; mem_ready = 1'b1; Zero = 1'b1; opcode = 6'h00; funct = 6'h20;
        #3 check("reset_async", outs(), 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_held", outs(), 16'h0);
        mem_ready = 1'b0;
        #2 rst = 1'b1;
        #1 check("release_fetch", outs(), mk(0,1,0,0,0,0,0,0,0,0,0,0));
        @(posedge clk); #1;
        @(negedge clk);
        check("fetch_wait", outs(), mk(0,1,0,0,0,0,0,0,0,0,0,0));
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) run_vec(i);

        // lw with two MEM wait states
        Zero = 1'b0;
        build(6'h23, 6'h11, 1'b0, 0, 2);
        apply("lw_wait");

        // Reset during a sw MEM wait abandons the store
        opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("sw_mem_wait", outs(), mk(0,0,1,0,0,0,0,1,0,0,0,0));
        #2 rst = 1'b0;
        #1 check("sw_reset_drop", outs(), 16'h0);
        @(posedge clk);
        @(negedge clk);
        check("sw_reset_hold", outs(), 16'h0);
        #2 rst = 1'b1;
        #1 check("sw_release_fetch", outs(), mk(0,1,0,0,0,0,0,0,0,0,0,0));
        @(posedge clk); #1;

        // Random instruction stream with random wait states
        for (int n = 0; n < 200; n++) begin
            int         oi, fi;
            logic [5:0] op, fn;
            oi = int'($urandom_range(0, 12));
            fi = int'($urandom_range(0, 9));
            op = (oi == 12) ? rb6() : op_pool[oi];
            fn = (fi == 9)  ? rb6() : fn_pool[fi];
            Zero = 1'($urandom);
            build(op, fn, Zero, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            apply($sformatf("rnd%0d op%h fn%h", n, op, fn));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
